sqrt_scheduler: RTL and testbench
=================================

SQRT_SCHEDULER -- requirements
Module: sqrt_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one square-root datapath.
REQ-002 The block SHALL have parameter NBITSIN, default 32, operand width.
REQ-003 The block SHALL have parameter NITER, default 20, datapath iteration cycles between start and stop.
REQ-004 The block SHALL have port clock  input  1  master clock, rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port req_valid  input  NREQ  per-requester operand valid.
REQ-007 The block SHALL have port req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-008 The block SHALL have port req_x  input  NREQ*NBITSIN  packed operands, requester i at bits [i*NBITSIN +: NBITSIN].
REQ-009 The block SHALL have port sq_start  output  1  datapath start pulse.
REQ-010 The block SHALL have port sq_stop  output  1  datapath stop pulse, which loads the datapath output register.
REQ-011 The block SHALL have port sq_xin  output  NBITSIN  registered operand to the datapath.
REQ-012 The block SHALL have port sq_sqrt  input  NBITSIN/2  rounded datapath result.
REQ-013 The block SHALL have port rsp_valid  output  1  result valid.
REQ-014 The block SHALL have port rsp_ready  input  1  result accept.
REQ-015 The block SHALL have port rsp_data  output  NBITSIN/2  result.
REQ-016 The block SHALL have port rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-017 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have six states: IDLE, START, RUN, STOP, CAPT and RESP.
REQ-019 In IDLE with any req_valid high, the block SHALL raise req_ready only for the round-robin winner, combinationally in that same cycle.
REQ-020 On the accept cycle T, the block SHALL register the winner's operand into sq_xin and its index into the id register, then enter START.
REQ-021 Round-robin priority SHALL start at 0 after reset and move to (winner+1) mod NREQ on each accept.
REQ-022 With NREQ not a power of two, the pointer SHALL wrap from NREQ-1 to 0.
REQ-023 START SHALL assert sq_start for exactly one cycle (T+1).
REQ-024 RUN SHALL last exactly NITER cycles (T+2 .. T+1+NITER), timed by a down-counter loaded with NITER-1 on entry.
REQ-025 STOP SHALL assert sq_stop for exactly one cycle (T+2+NITER).
REQ-026 CAPT (T+3+NITER) SHALL register sq_sqrt into rsp_data.
REQ-027 RESP SHALL begin at T+4+NITER; with the defaults, rsp_valid rises 24 cycles after the accept.
REQ-028 In RESP, rsp_valid, rsp_data and rsp_id SHALL hold stable until rsp_ready is sampled high, then the FSM SHALL return to IDLE.
REQ-029 rsp_ready high in the cycle rsp_valid rises SHALL complete the transfer in that cycle.
REQ-030 req_ready SHALL be 0 in every state except IDLE, so no new grant occurs while a result is pending.
REQ-031 A requester that drops req_valid before it is granted SHALL simply not be granted.
REQ-032 sq_start and sq_stop SHALL never be asserted in the same cycle, and neither SHALL be asserted outside START or STOP respectively.
REQ-033 Operand 0 SHALL be handled like any other operand, with no special case.

Reset
REQ-034 On reset, state SHALL go to IDLE, the pointer to 0 and the counter to 0.
REQ-035 On reset, all outputs SHALL go to 0: req_ready, sq_start, sq_stop, sq_xin, rsp_valid, rsp_data, rsp_id and busy.
REQ-036 Reset asserted in any state, including mid-RUN, SHALL discard the operation without generating a response.
REQ-037 After reset is released, the first new request SHALL be served with the normal timing.

Structure
REQ-038 Package sqrt_sched_pkg SHALL hold the state enum, the default NITER and the ID-width function.
REQ-039 Sub-module rr_arbiter SHALL contain the combinational round-robin grant logic (req vector plus pointer in, one-hot grant out); the block SHALL own the pointer register.
REQ-040 The square-root datapath SHALL be instantiated by the parent, not inside this block.

Verification
REQ-041 A single request, requester 0 with x=144, accepted at T, SHALL give sq_start at T+1, sq_stop at T+22, and rsp_valid at T+24 with rsp_data=12 and rsp_id=0.
REQ-042 All four req_valid held high with rsp_ready=1 SHALL produce grants in order 0,1,2,3,0; requester 2 with x=1000000 SHALL return 1000.
REQ-043 rsp_ready held low for 5 cycles in RESP SHALL keep rsp_valid, rsp_data and rsp_id stable, and req_ready SHALL stay 0 throughout.
REQ-044 Reset asserted at T+10 during RUN SHALL drive all outputs to 0 at the next edge and produce no response; a following request x=6 SHALL return 2.
REQ-045 x=0xFFFE0001 SHALL return 65535, and x=0 SHALL return 0.
REQ-046 With NREQ=3, requests from 2 then 0 SHALL show the pointer wrapping to 0 after granting 2.

Source files
------------

// File: rtl/sqrt_scheduler_pkg.sv
// rtl/sqrt_scheduler_pkg.sv - shared state type, defaults and id-width helper for the sqrt scheduler
package sqrt_sched_pkg;

  localparam int DEFAULT_NITER = 20;

  typedef enum logic [2:0] {IDLE, START, RUN, STOP, CAPT, RESP} state_t;

  // A single requester still needs a 1-bit id so the port never collapses to zero width.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt_scheduler_if.sv
// rtl/sqrt_scheduler_if.sv - request, datapath and response signals of the sqrt scheduler
interface sqrt_scheduler_if #(
  parameter int NREQ    = 4,
  parameter int NBITSIN = 32
);
  import sqrt_sched_pkg::*;

  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*NBITSIN-1:0] req_x;
  logic                    sq_start;
  logic                    sq_stop;
  logic [NBITSIN-1:0]      sq_xin;
  logic [NBITSIN/2-1:0]    sq_sqrt;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [NBITSIN/2-1:0]    rsp_data;
  logic [IDW-1:0]          rsp_id;
  logic                    busy;

  modport master (
    input  req_valid, req_x, sq_sqrt, rsp_ready,
    output req_ready, sq_start, sq_stop, sq_xin, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    output req_valid, req_x, sq_sqrt, rsp_ready,
    input  req_ready, sq_start, sq_stop, sq_xin, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/sqrt_scheduler_rr_arbiter.sv
// rtl/sqrt_scheduler_rr_arbiter.sv - combinational round-robin grant, highest priority at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [PW-1:0] idx;

  // Walk from lowest to highest priority so the last hit, the one nearest ptr, wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) grant = NREQ'(1) << idx;
    end
  end

endmodule

// File: rtl/sqrt_scheduler.sv
// rtl/sqrt_scheduler.sv - shares one external square-root datapath among NREQ requesters
module sqrt_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int NBITSIN = 32,
  parameter int NITER   = DEFAULT_NITER
) (
  input logic       clock,
  input logic       reset,
  sqrt_scheduler_if.master bus
);

  localparam int IDW = id_width(NREQ);
  localparam int CW  = (NITER > 1) ? $clog2(NITER) : 1;

  state_t               state;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       id;
  logic [IDW-1:0]       winner;
  logic [CW-1:0]        cnt;
  logic [NREQ-1:0]      grant;
  logic [NBITSIN-1:0]   operand;

  rr_arbiter #(.NREQ(NREQ), .PW(IDW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    winner  = '0;
    operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        winner  = IDW'(i);
        operand = bus.req_x[i*NBITSIN +: NBITSIN];
      end
    end
  end

  assign bus.req_ready = (state == IDLE && !reset) ? grant : '0;
  assign bus.rsp_id    = id;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      id            <= '0;
      bus.sq_start  <= 1'b0;
      bus.sq_stop   <= 1'b0;
      bus.sq_xin    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            bus.sq_xin   <= operand;
            id           <= winner;
            ptr          <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
            bus.sq_start <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          bus.sq_start <= 1'b0;
          cnt          <= CW'(NITER - 1);
          state        <= RUN;
        end
        RUN: begin
          if (cnt == '0) begin
            bus.sq_stop <= 1'b1;
            state       <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          bus.sq_stop <= 1'b0;
          state       <= CAPT;
        end
        // The datapath loaded its output register on the stop edge; take it now.
        CAPT: begin
          bus.rsp_data  <= bus.sq_sqrt;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_scheduler.sv
// tb/tb_sqrt_scheduler.sv - scoreboard bench for sqrt_scheduler with directed and randomized requests
`timescale 1ns/1ps
module tb_sqrt_scheduler;
  import sqrt_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int NB    = 32;
  localparam int NITER = 20;
  localparam int LAT   = NITER + 4;

  typedef longint unsigned u64_t;
  typedef struct { int id; logic [15:0] data; int t; } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sqrt_scheduler_if #(.NREQ(NREQ), .NBITSIN(NB)) bus ();
  sqrt_scheduler_if #(.NREQ(3), .NBITSIN(NB)) bus3 ();

  sqrt_scheduler #(.NREQ(NREQ), .NBITSIN(NB), .NITER(NITER)) dut (
    .clock (clock), .reset (reset), .bus (bus));
  sqrt_scheduler #(.NREQ(3), .NBITSIN(NB), .NITER(NITER)) dut3 (
    .clock (clock), .reset (reset), .bus (bus3));

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  exp_t sbq[$];
  int   dut_grants[$];
  int   issued = 0, done = 0, last_done_cyc = -1, model_ptr = 0;
  int   w, j;
  exp_t ne, e;
  logic [15:0] last_rsp [NREQ];
  logic [NREQ-1:0] acc;
  int   exp_order[5] = '{0, 1, 2, 3, 0};
  int   g0;

  always @(posedge clock) cyc <= cyc + 1;

  // Datapath stand-in: bitwise integer root with round-to-nearest, loaded on sq_stop.
  function automatic logic [15:0] dp_sqrt(input logic [31:0] x);
    u64_t xx = {32'd0, x};
    u64_t r = 0;
    u64_t t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (u64_t'(1) << b);
      if (t * t <= xx) r = t;
    end
    if (xx - r * r > r) r = r + 1;
    if (r > 65535) r = 65535;
    return r[15:0];
  endfunction

  // Reference: real square root rounded to nearest, clamped to the result width.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
    longint xl = {32'd0, x};
    real    r;
    longint v;
    r = xl;
    v = longint'($sqrt(r));
    if (v > 65535) v = 65535;
    return v[15:0];
  endfunction

  always @(posedge clock) begin
    if (reset) bus.sq_sqrt <= '0;
    else if (bus.sq_stop) bus.sq_sqrt <= dp_sqrt(bus.sq_xin);
  end
  always @(posedge clock) begin
    if (reset) bus3.sq_sqrt <= '0;
    else if (bus3.sq_stop) bus3.sq_sqrt <= dp_sqrt(bus3.sq_xin);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: wait expired without the event, required it within the bound (cycle %0d)", name, cyc);
  endtask

  // Grant model: predicts the round-robin winner and queues the expected response.
  always @(negedge clock) begin
    if (reset) begin
      check("req_ready_in_reset", bus.req_ready, 0);
      model_ptr = 0;
      issued = 0;
    end else if (issued == done && cyc > last_done_cyc && |bus.req_valid) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (model_ptr + k) % NREQ;
        if (w < 0 && bus.req_valid[j]) w = j;
      end
      check("grant", bus.req_ready, 64'd1 << w);
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) dut_grants.push_back(i);
      ne.id = w;
      ne.data = ref_sqrt(bus.req_x[w*NB +: NB]);
      ne.t = cyc;
      sbq.push_back(ne);
      model_ptr = (w + 1) % NREQ;
      issued++;
    end else begin
      check("req_ready_zero", bus.req_ready, 0);
    end
  end

  // Monitor: checks pulse timing and pops the scoreboard on each response transfer.
  always @(negedge clock) begin
    if (reset) begin
      sbq.delete();
      done = 0;
      last_done_cyc = cyc;
    end else if (sbq.size() > 0) begin
      e = sbq[0];
      check("sq_start", bus.sq_start, cyc == e.t + 1);
      check("sq_stop", bus.sq_stop, cyc == e.t + 2 + NITER);
      check("busy", bus.busy, cyc > e.t);
      check("rsp_valid", bus.rsp_valid, cyc >= e.t + LAT);
      if (bus.rsp_valid) begin
        check("rsp_id", bus.rsp_id, e.id);
        check("rsp_data", bus.rsp_data, e.data);
        if (bus.rsp_ready) begin
          last_rsp[e.id] = bus.rsp_data;
          void'(sbq.pop_front());
          done++;
          last_done_cyc = cyc;
        end
      end
    end else begin
      check("idle_sq_start", bus.sq_start, 0);
      check("idle_sq_stop", bus.sq_stop, 0);
      check("idle_rsp_valid", bus.rsp_valid, 0);
      check("idle_busy", bus.busy, 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_sq_start", bus.sq_start, 0);
    check("rst_sq_stop", bus.sq_stop, 0);
    check("rst_sq_xin", bus.sq_xin, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_busy", bus.busy, 0);
    repeat (n - 1) tick();
    reset = 1'b0;
  endtask

  task automatic wait_accept(input int idx);
    bit ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clock);
      if (bus.req_valid[idx] && bus.req_ready[idx]) ok = 1;
    end
    if (!ok) fail_now("accept_wait");
    tick();
  endtask

  task automatic request(input int idx, input logic [31:0] x);
    bus.req_x[idx*NB +: NB] = x;
    bus.req_valid[idx] = 1'b1;
    wait_accept(idx);
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clock);
      if (sbq.size() == 0 && !bus.busy) ok = 1;
    end
    if (!ok) fail_now("drain_wait");
    tick();
  endtask

  function automatic logic [31:0] rand_x();
    logic [31:0] k;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 1000));
      3: begin k = 32'($urandom_range(0, 65535)); return k * k; end
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    bus.req_valid = '0;  bus.req_x = '0;  bus.rsp_ready = 1'b0;
    bus3.req_valid = '0; bus3.req_x = '0; bus3.rsp_ready = 1'b1;
    do_reset(3);

    // Single request with the classic 144 -> 12 example.
    bus.rsp_ready = 1'b1;
    request(0, 32'd144);
    drain();
    check("single_144", last_rsp[0], 12);

    // All four held valid: grants must rotate 0,1,2,3,0 from a fresh pointer.
    do_reset(2);
    bus.req_x = {32'd17, 32'd1000000, 32'd50, 32'd9};
    g0 = dut_grants.size();
    bus.req_valid = 4'hF;
    for (int c = 0; c < 400 && dut_grants.size() < g0 + 5; c++) @(negedge clock);
    if (dut_grants.size() < g0 + 5) fail_now("rotation_wait");
    tick();
    bus.req_valid = '0;
    drain();
    for (int k = 0; k < 5; k++) check($sformatf("rotation_%0d", k), dut_grants[g0 + k], exp_order[k]);
    check("rotation_x1000000", last_rsp[2], 1000);

    // Response back-pressure while another requester waits.
    bus.rsp_ready = 1'b0;
    bus.req_x[3*NB +: NB] = 32'd81;
    bus.req_valid[3] = 1'b1;
    request(1, 32'd400);
    for (int c = 0; c < 100 && !bus.rsp_valid; c++) @(negedge clock);
    if (!bus.rsp_valid) fail_now("bp_valid_wait");
    repeat (5) @(negedge clock);
    tick();
    bus.rsp_ready = 1'b1;
    wait_accept(3);
    bus.req_valid[3] = 1'b0;
    drain();
    check("bp_x400", last_rsp[1], 20);
    check("bp_x81", last_rsp[3], 9);

    // Reset in the middle of RUN drops the operation; the next request runs normally.
    request(2, 32'd12345);
    repeat (9) tick();
    do_reset(1);
    repeat (30) tick();
    request(0, 32'd6);
    drain();
    check("after_reset_x6", last_rsp[0], 2);

    request(1, 32'hFFFE_0001);
    drain();
    check("max_square", last_rsp[1], 65535);
    request(3, 32'd0);
    drain();
    check("zero_operand", last_rsp[3], 0);

    // Randomized traffic with random back-pressure and occasional withdrawn requests.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      acc = bus.req_valid & bus.req_ready;
      tick();
      bus.rsp_ready = ($urandom_range(0, 99) < 70);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || (bus.req_valid[i] && $urandom_range(0, 99) < 3)) begin
          bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i] && $urandom_range(0, 99) < 20) begin
          bus.req_x[i*NB +: NB] = rand_x();
          bus.req_valid[i] = 1'b1;
        end
      end
    end
    @(negedge clock);
    acc = bus.req_valid & bus.req_ready;
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    drain();

    // Three requesters: after granting 2 the pointer must wrap to 0.
    bus3.req_valid = 3'b100;
    for (int c = 0; c < 100 && bus3.req_ready == '0; c++) @(negedge clock);
    check("n3_grant_2", bus3.req_ready, 3'b100);
    tick();
    bus3.req_valid = 3'b111;
    tick();
    for (int c = 0; c < 100 && bus3.req_ready == '0; c++) @(negedge clock);
    check("n3_wrap_to_0", bus3.req_ready, 3'b001);
    tick();
    tick();
    for (int c = 0; c < 100 && bus3.req_ready == '0; c++) @(negedge clock);
    check("n3_then_1", bus3.req_ready, 3'b010);
    tick();
    bus3.req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
